// File: rtl/mem_access_sequencer.sv
// Request sequencer in front of memory_controller: issues loads, stores and read bursts,
// waits out the read latency, and returns per-beat data with fault flags.
module mem_access_sequencer #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [15:0] ROM_TOP      = 16'h001F,
    parameter logic [15:0] MAP_TOP      = 16'h005F
) (
    input  logic        clock,
    input  logic        reset_n,
    // Both channels: a transfer happens on a rising edge where valid and ready are both high;
    // once raised, resp_valid and its payload stay put until that transfer.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [4:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_last,
    output logic        resp_fault,
    output logic [15:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state_o
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  beats_q, beats_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        last_q, last_d;
    logic        fault_q, fault_d;
    logic        fault;
    logic        capture;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            last_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        fault_d = fault_q;

        // Fault is evaluated per beat against the current (possibly incremented) address.
        fault   = (addr_q > MAP_TOP) || (we_q && (addr_q <= ROM_TOP));
        capture = ((state_q == ISSUE) && (LAT == 3'd0)) ||
                  ((state_q == WAIT) && (cnt_q == 3'd1));

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    beats_d = req_we ? 5'd0 : req_len;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT;
                state_d = (LAT == 3'd0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (beats_q == 5'd0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 16'd1;
                        beats_d = beats_q - 5'd1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            rdata_d = (we_q || fault) ? 32'd0 : mem_rdata;
            fault_d = fault;
            last_d  = (beats_q == 5'd0);
        end
    end

    assign req_ready   = (state_q == IDLE) && reset_n;
    assign resp_valid  = (state_q == RESP);
    assign resp_data   = rdata_q;
    assign resp_last   = last_q;
    assign resp_fault  = fault_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = (state_q == ISSUE) && we_q && !fault;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed vector table, stall and mid-burst reset
// sequences, then random requests checked against a per-beat reference model.
module tb_mem_access_sequencer;

    localparam int          RL      = 1;
    localparam logic [15:0] ROM_TOP = 16'h001F;
    localparam logic [15:0] MAP_TOP = 16'h005F;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [4:0]  req_len;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_last, resp_fault;
    logic [15:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state_o;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;

    logic [31:0] env_mem [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic [31:0] rd_pipe [0:7];
    logic [47:0] exp_wr_q[$];

    logic [31:0] obs_data0;
    logic        obs_fault0;
    int          obs_beats;

    always #5 clock = ~clock;

    mem_access_sequencer #(
        .READ_LATENCY(RL),
        .ROM_TOP     (ROM_TOP),
        .MAP_TOP     (MAP_TOP)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .resp_fault (resp_fault),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .dbg_state_o(dbg_state_o)
    );

    // Behavioural memory_controller: data_out valid RL cycles after the address.
    always @(posedge clock) begin
        rd_pipe[0] <= env_mem[mem_address];
        for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_we) env_mem[mem_address] <= mem_wdata;
    end
    assign mem_rdata = (RL == 0) ? env_mem[mem_address] : rd_pipe[(RL == 0) ? 0 : RL - 1];

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return (a == 16'h0003) ? 32'hDEADBEEF : {16'hC0DE, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Write scoreboard: every cycle with mem_we high must match the next expected store.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            logic [47:0] e;
            wr_seen++;
            checks++;
            if (exp_wr_q.size() == 0) begin
                failures++;
                $display("FAIL mem_we_unexpected: got addr=%h data=%h expected no write", mem_address, mem_wdata);
            end else begin
                e = exp_wr_q.pop_front();
                if ({mem_address, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL mem_write: got %h/%h expected %h/%h", mem_address, mem_wdata, e[47:32], e[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        @(negedge clock);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_last", 32'(resp_last), 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_req_ready_low", 32'(req_ready), 32'd0);
        check("rst_dbg_state_idle", 32'(dbg_state_o), 32'd0);
        exp_wr_q.delete();
        reset_n = 1'b1;
        #1;
        check("rst_req_ready_high", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [4:0] len,
                          input logic [31:0] wdata, input int min_stall, input int max_stall);
        int          nbeats, k, wr_before, exp_writes, stall;
        logic [15:0] a;
        logic        f;
        logic [31:0] ed;
        nbeats     = we ? 1 : int'(len) + 1;
        wr_before  = wr_seen;
        exp_writes = 0;
        obs_beats  = 0;
        obs_data0  = 32'hXXXXXXXX;
        obs_fault0 = 1'bx;
        if (we && !((addr > MAP_TOP) || (addr <= ROM_TOP))) begin
            exp_wr_q.push_back({addr, wdata});
            ref_mem[addr] = wdata;
            exp_writes = 1;
        end
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("req_ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        req_wdata = wdata;
        @(negedge clock);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 16'($urandom);
        req_len   = 5'($urandom);
        req_wdata = $urandom;
        for (int b = 0; b < nbeats; b++) begin
            a  = addr + 16'(b);
            f  = (a > MAP_TOP) || (we && (a <= ROM_TOP));
            ed = (we || f) ? 32'd0 : ref_mem[a];
            k  = 0;
            while (resp_valid !== 1'b1 && k < 40) begin
                @(negedge clock);
                k++;
            end
            check("resp_latency", 32'(k), 32'(1 + RL));
            if (resp_valid === 1'b1) obs_beats++;
            if (b == 0) begin
                obs_data0  = resp_data;
                obs_fault0 = resp_fault;
            end
            check("resp_data", resp_data, ed);
            check("resp_fault", 32'(resp_fault), 32'(f));
            check("resp_last", 32'(resp_last), 32'(b == nbeats - 1));
            check("mem_address_beat", 32'(mem_address), 32'(a));
            stall = $urandom_range(max_stall, min_stall);
            repeat (stall) begin
                @(negedge clock);
                check("stall_resp_valid", 32'(resp_valid), 32'd1);
                check("stall_resp_data", resp_data, ed);
                check("stall_mem_address", 32'(mem_address), 32'(a));
            end
            resp_ready = 1'b1;
            @(negedge clock);
            resp_ready = 1'b0;
        end
        check("resp_valid_after_last", 32'(resp_valid), 32'd0);
        check("req_ready_after_last", 32'(req_ready), 32'd1);
        check("mem_we_pulses", 32'(wr_seen - wr_before), 32'(exp_writes));
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [4:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp_data0;
        logic        exp_fault0;
        int          exp_beats;
    } vec_t;

    vec_t vecs [15];

    initial begin : main
        int k;
        vecs[0]  = '{1'b0, 16'h0003, 5'd0, 32'h0,        32'hDEADBEEF, 1'b0, 1};
        vecs[1]  = '{1'b1, 16'h0045, 5'd0, 32'h12345678, 32'h0,        1'b0, 1};
        vecs[2]  = '{1'b0, 16'h0045, 5'd0, 32'h0,        32'h12345678, 1'b0, 1};
        vecs[3]  = '{1'b1, 16'h0010, 5'd0, 32'hAAAA5555, 32'h0,        1'b1, 1};
        vecs[4]  = '{1'b1, 16'h0070, 5'd0, 32'h5555AAAA, 32'h0,        1'b1, 1};
        vecs[5]  = '{1'b0, 16'h0070, 5'd0, 32'h0,        32'h0,        1'b1, 1};
        vecs[6]  = '{1'b0, 16'h005E, 5'd3, 32'h0,        32'hC0DE005E, 1'b0, 4};
        vecs[7]  = '{1'b1, 16'h0050, 5'd5, 32'h0BADF00D, 32'h0,        1'b0, 1};
        vecs[8]  = '{1'b0, 16'h0050, 5'd0, 32'h0,        32'h0BADF00D, 1'b0, 1};
        vecs[9]  = '{1'b1, 16'h001F, 5'd0, 32'h99999999, 32'h0,        1'b1, 1};
        vecs[10] = '{1'b1, 16'h0020, 5'd0, 32'h11112222, 32'h0,        1'b0, 1};
        vecs[11] = '{1'b0, 16'h005F, 5'd1, 32'h0,        32'hC0DE005F, 1'b0, 2};
        vecs[12] = '{1'b0, 16'h0060, 5'd0, 32'h0,        32'h0,        1'b1, 1};
        vecs[13] = '{1'b0, 16'hFFFE, 5'd2, 32'h0,        32'h0,        1'b1, 3};
        vecs[14] = '{1'b0, 16'h001F, 5'd0, 32'h0,        32'hC0DE001F, 1'b0, 1};

        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = init_word(16'(i));
            ref_mem[i] = init_word(16'(i));
        end
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].wdata, 0, 1);
            check("vec_data0", obs_data0, vecs[i].exp_data0);
            check("vec_fault0", 32'(obs_fault0), 32'(vecs[i].exp_fault0));
            check("vec_beats", 32'(obs_beats), 32'(vecs[i].exp_beats));
        end

        // Five-cycle response backpressure on every beat of a burst.
        do_req(1'b0, 16'h0044, 5'd3, 32'h0, 5, 5);

        // Reset during WAIT of the second beat of a four-beat burst.
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0040;
        req_len   = 5'd3;
        @(negedge clock);
        req_valid = 1'b0;
        k = 0;
        while (resp_valid !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("mid_rst_beat1", resp_data, ref_mem[16'h0040]);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        @(negedge clock);
        check("mid_rst_wait_no_resp", 32'(resp_valid), 32'd0);
        check("mid_rst_wait_addr", 32'(mem_address), 32'h0041);
        do_reset();
        resp_ready = 1'b1;
        repeat (6) begin
            @(negedge clock);
            check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
        end
        resp_ready = 1'b0;
        do_req(1'b0, 16'h0000, 5'd0, 32'h0, 0, 0);

        // Random requests against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic        rwe;
            logic [15:0] raddr;
            rwe   = ($urandom_range(0, 2) == 0);
            raddr = ($urandom_range(0, 9) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                                : 16'($urandom_range(0, 16'h0070));
            do_req(rwe, raddr, 5'($urandom_range(0, 7)), $urandom, 0, 3);
        end

        check("exp_writes_drained", 32'(exp_wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sits directly upstream of memory_controller, between the CPU datapath and the memory address map.
- Accepts single-word load/store requests and multi-word read bursts over a valid/ready handshake.
- Sequences address, write-enable and write data into memory_controller, waits out the read latency, and returns captured data over a valid/ready response channel.
- Flags accesses to unmapped space and writes to ROM as faults, and suppresses those writes.

Parameters:
- READ_LATENCY, 1, clock cycles from address issue until memory_controller data_out is valid (0..7).
- ROM_TOP, 16'h001F, highest ROM address; writes at or below it fault.
- MAP_TOP, 16'h005F, highest mapped address; any access above it faults.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_we  in  1  1 = store (single word), 0 = load/burst read
- req_addr  in  16  start word address
- req_len  in  5  beats minus 1 (reads only; ignored and forced to 0 when req_we=1)
- req_wdata  in  32  store data
- resp_valid  out  1  response beat present
- resp_ready  in  1  consumer accepts beat
- resp_data  out  32  read data (0 for stores and faulted reads)
- resp_last  out  1  final beat of request
- resp_fault  out  1  beat address was unmapped, or was a ROM write
- mem_address  out  16  to memory_controller address
- mem_wdata  out  32  to memory_controller data_in
- mem_we  out  1  to memory_controller we
- mem_rdata  in  32  from memory_controller data_out

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a clock edge) overrides everything, including a request or burst mid-operation:
  - FSM goes to IDLE; the burst is abandoned and no response is produced.
  - req_ready=0 during reset, then 1 from IDLE.
  - resp_valid=0, resp_data=0, resp_last=0, resp_fault=0.
  - mem_address=0, mem_wdata=0, mem_we=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, we, wdata, and beats_left = (we ? 0 : req_len); go to ISSUE.
  - req_ready=0 in every other state.
- ISSUE (exactly 1 cycle):
  - mem_address = current address; mem_wdata = latched wdata.
  - mem_we = we AND NOT fault. It is asserted only in ISSUE, for exactly one cycle per store.
  - fault = (addr > MAP_TOP) OR (we AND addr <= ROM_TOP).
  - Load wait counter with READ_LATENCY. If READ_LATENCY=0, capture and go to RESP; otherwise go to WAIT.
- WAIT:
  - mem_address is held.
  - Counter decrements each cycle. On the cycle it reaches 1, capture at the clock edge and go to RESP.
- Capture rule:
  - resp_data = (we OR fault) ? 0 : mem_rdata.
  - resp_fault = fault.
  - resp_last = (beats_left == 0).
- RESP:
  - resp_valid=1; resp_data, resp_last and resp_fault stay stable until resp_ready.
  - On resp_valid AND resp_ready:
    - If beats_left == 0, go to IDLE.
    - Otherwise addr = addr + 1 (mod 2^16, so 16'hFFFF wraps to 16'h0000), beats_left decrements, go to ISSUE.
  - Back-to-back: a new request can be accepted no earlier than the cycle after the final handshake, when the FSM is in IDLE.
- Latency: request accepted at edge T → resp_valid first high in cycle T+2+READ_LATENCY. Each subsequent burst beat follows 2+READ_LATENCY cycles after the previous handshake.
- Faults are per beat. A burst crossing MAP_TOP continues: mapped beats return data, unmapped beats return 0 with fault=1. A fault never aborts the burst.
- resp_valid deasserts the cycle after the final handshake.

Test Plan:
- Reset, then load req_addr=16'h0003, READ_LATENCY=1, ROM word 3 = 32'hDEADBEEF → accepted at T, resp_valid at T+3, resp_data=DEADBEEF, resp_last=1, resp_fault=0, mem_we never high.
- Store req_addr=16'h0045, wdata=32'h12345678, then load 0x0045 → mem_we high exactly one cycle with mem_address=0x0045; store response has data 0, fault 0; load returns 12345678.
- Store to 16'h0010 (ROM) → mem_we stays 0, resp_fault=1, resp_last=1; store to 0x0070 → resp_fault=1, mem_we 0.
- Burst read req_addr=16'h005E, req_len=3 → four beats at addresses 5E,5F,60,61; fault=0,0,1,1; beats 3–4 data=0; resp_last only on beat 4.
- Hold resp_ready=0 for 5 cycles during a burst → resp_valid, resp_data and mem_address stable; no address advance until the handshake.
- Assert reset_n=0 during WAIT of beat 2 of a 4-beat burst → next cycle all outputs are at reset values and req_ready=1 after release; a fresh load of 0x0000 completes normally.
